// File: rtl/yuv422_unpacker_if.sv
// Byte-in / pixel-out bus of the 4:2:2 unpacker. The slave side is the unpacker.
// The master side drives CTE bytes and downstream ready.
interface yuv422_unpacker_if #(
   parameter int AW = 2
);
   logic          in_valid;
   logic [7:0]    in_byte;
   logic          phase_clr;
   logic          pix_ready;
   logic          pix_valid;
   logic [23:0]   pix_yuv;
   logic [AW:0]   level;
   logic          overflow;
   logic [1:0]    phase;

   modport master (
      output in_valid, in_byte, phase_clr, pix_ready,
      input  pix_valid, pix_yuv, level, overflow, phase
   );

   modport slave (
      input  in_valid, in_byte, phase_clr, pix_ready,
      output pix_valid, pix_yuv, level, overflow, phase
   );
endinterface

// File: rtl/yuv422_unpacker.sv
// Reassembles the serial U,Y0,V,Y1 byte stream into pixel pairs and buffers them.
// Each stored pair is emitted as two 4:4:4 pixels {Y,U,V} over a ready/valid port.
module yuv422_unpacker #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic               clk,
   input  logic               reset,
   yuv422_unpacker_if.slave   bus
);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [1:0]    phase_q;
   logic [7:0]    u_q, y0_q, v_q;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level_q;
   logic          half_q;
   logic          ovf_q;

   logic          byte_take;
   logic          push;
   logic          push_ok;
   logic          pair_pop;
   logic          xfer;
   logic          not_empty;
   logic [31:0]   head;

   assign byte_take = bus.in_valid & ~bus.phase_clr;
   assign push      = byte_take & (phase_q == 2'd3);
   assign not_empty = (level_q != '0);
   assign xfer      = not_empty & bus.pix_ready;
   assign pair_pop  = xfer & half_q;
   // A full FIFO still accepts the pair when the head leaves on the same edge.
   assign push_ok   = push & ((level_q != LVL_FULL) | pair_pop);
   assign head      = mem[rd_ptr];

   // Stored word layout: {U, Y0, V, Y1}.
   always_comb begin
      bus.pix_yuv = 24'h0;
      if (not_empty)
         bus.pix_yuv = {(half_q ? head[7:0] : head[23:16]), head[31:24], head[15:8]};
   end

   assign bus.pix_valid = not_empty;
   assign bus.level     = level_q;
   assign bus.overflow  = ovf_q;
   assign bus.phase     = phase_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= 2'd0;
         u_q     <= 8'h0;
         y0_q    <= 8'h0;
         v_q     <= 8'h0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         half_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (bus.phase_clr)
            phase_q <= 2'd0;
         else if (bus.in_valid)
            phase_q <= phase_q + 2'd1;

         if (byte_take) begin
            case (phase_q)
               2'd0:    u_q  <= bus.in_byte;
               2'd1:    y0_q <= bus.in_byte;
               2'd2:    v_q  <= bus.in_byte;
               default: ;
            endcase
         end

         if (push_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pair_pop)
            rd_ptr <= rd_ptr + PTR_ONE;

         case ({push_ok, pair_pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: ;
         endcase

         if (xfer)
            half_q <= ~half_q;

         if (push & ~push_ok)
            ovf_q <= 1'b1;
      end
   end

   // Storage carries no reset; occupancy is tracked by level_q alone.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= {u_q, y0_q, v_q, bus.in_byte};
   end
endmodule

// File: tb/tb_yuv422_unpacker.sv
// Directed bench for yuv422_unpacker: expected pixels are queued at stimulus time
// and a forked monitor compares every accepted pixel against the queue head.
module tb_yuv422_unpacker;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   yuv422_unpacker_if #(.AW(AW)) bus ();

   yuv422_unpacker #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [23:0] exp_q [$];
   logic [23:0] mon_exp;
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_byte  = b;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [7:0] u, y0, v, y1, input bit expect_out);
      if (expect_out) begin
         exp_q.push_back({y0, u, v});
         exp_q.push_back({y1, u, v});
      end
      send(u);
      send(y0);
      send(v);
      send(y1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.level != '0) && n < 300) begin
         step();
         n++;
      end
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_level", 32'(bus.level), 0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_byte   = 8'h0;
      bus.phase_clr = 1'b0;
      bus.pix_ready = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (!reset && bus.pix_valid && bus.pix_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_pixel: got %h expected none", bus.pix_yuv);
               end else begin
                  mon_exp = exp_q.pop_front();
                  chk("pixel", 32'(bus.pix_yuv), 32'(mon_exp));
               end
            end
         end
      join_none

      repeat (2) step();
      chk("rst_pix_valid", 32'(bus.pix_valid), 0);
      chk("rst_pix_yuv",   32'(bus.pix_yuv),   0);
      chk("rst_level",     32'(bus.level),     0);
      chk("rst_overflow",  32'(bus.overflow),  0);
      chk("rst_phase",     32'(bus.phase),     0);
      reset = 1'b0;
      step();

      // Back-to-back group, always ready.
      bus.pix_ready = 1'b1;
      send_pair(8'h80, 8'h10, 8'h7F, 8'h20, 1'b1);
      chk("t1_first_valid", 32'(bus.pix_valid), 1);
      drain();
      chk("t1_overflow", 32'(bus.overflow), 0);

      // Same group with 3 idle cycles between bytes.
      exp_q.push_back(24'h10807F);
      exp_q.push_back(24'h20807F);
      begin
         logic [7:0] bytes [4];
         bytes = '{8'h80, 8'h10, 8'h7F, 8'h20};
         for (int i = 0; i < 4; i++) begin
            send(bytes[i]);
            chk("t2_phase", 32'(bus.phase), 32'((i + 1) % 4));
            repeat (3) step();
         end
      end
      drain();

      // Five pairs into a stalled FIFO; the fifth is dropped.
      bus.pix_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send_pair(8'h40 + 8'(k), 8'h01 + 8'(k), 8'hC0 + 8'(k), 8'h11 + 8'(k), k < 4);
         if (k == 3) begin
            chk("t3_level_full", 32'(bus.level), 4);
            chk("t3_ovf_before", 32'(bus.overflow), 0);
         end
      end
      chk("t3_level_after", 32'(bus.level), 4);
      chk("t3_ovf_after", 32'(bus.overflow), 1);
      chk("t3_hold_pix", 32'(bus.pix_yuv), 32'h0140C0);
      step();
      chk("t3_hold_pix2", 32'(bus.pix_yuv), 32'h0140C0);
      bus.pix_ready = 1'b1;
      drain();
      chk("t3_ovf_sticky", 32'(bus.overflow), 1);

      // Clear overflow between tests.
      reset = 1'b1;
      #2;
      reset = 1'b0;
      exp_q.delete();
      step();

      // Full FIFO: Y1 arrives on the same edge as the pair-pop.
      bus.pix_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         send_pair(8'h50 + 8'(k), 8'h21 + 8'(k), 8'hA0 + 8'(k), 8'h31 + 8'(k), 1'b1);
      exp_q.push_back(24'hE7F0E9);
      exp_q.push_back(24'hE8F0E9);
      send(8'hF0);
      send(8'hE7);
      send(8'hE9);
      bus.pix_ready = 1'b1;
      step();
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hE8;
      step();
      bus.in_valid = 1'b0;
      chk("t4_level", 32'(bus.level), 4);
      chk("t4_overflow", 32'(bus.overflow), 0);
      drain();
      chk("t4_ovf_end", 32'(bus.overflow), 0);

      // phase_clr swallows the current byte and restarts at U.
      send(8'h11);
      send(8'h22);
      bus.in_valid  = 1'b1;
      bus.in_byte   = 8'h33;
      bus.phase_clr = 1'b1;
      step();
      bus.in_valid  = 1'b0;
      bus.phase_clr = 1'b0;
      chk("t5_phase_clr", 32'(bus.phase), 0);
      send_pair(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b1);
      drain();

      // Asynchronous reset mid-stream.
      bus.pix_ready = 1'b0;
      send_pair(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
      send_pair(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
      send(8'h09);
      send(8'h0A);
      chk("t6_level_pre", 32'(bus.level), 2);
      chk("t6_phase_pre", 32'(bus.phase), 2);
      reset = 1'b1;
      #2;
      chk("t6_async_valid", 32'(bus.pix_valid), 0);
      chk("t6_async_level", 32'(bus.level), 0);
      chk("t6_async_phase", 32'(bus.phase), 0);
      reset = 1'b0;
      step();
      bus.pix_ready = 1'b1;
      send_pair(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
      drain();
      chk("t6_overflow", 32'(bus.overflow), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
